// File: rtl/traffic_pkg.sv
// Shared definitions for the two-road traffic phase scheduler.
//   - phase_e   : state encoding, also driven out on the 3-bit phase port
//   - lamps_t   : one bundle of lamp/segment drives
//   - *_DEF     : default timing constants (in ticks)
//   - lamp_decode: lamp pattern for a given state
package traffic_pkg;

  localparam int TMR_W = 10;

  localparam int GX_T_DEF       = 300;
  localparam int GY_T_DEF       = 150;
  localparam int BLINK_T_DEF    = 40;
  localparam int BLINK_HALF_DEF = 10;
  localparam int CLR_T_DEF      = 20;
  localparam int MIN_G_DEF      = 100;

  typedef enum logic [2:0] {
    XG      = 3'd0,
    XB      = 3'd1,
    CLR_XY  = 3'd2,
    YG      = 3'd3,
    YB      = 3'd4,
    CLR_YX  = 3'd5,
    EMG_CLR = 3'd6,
    EMG     = 3'd7
  } phase_e;

  typedef struct packed {
    logic gx;
    logic rx;
    logic gy;
    logic ry;
    logic seg;
  } lamps_t;

  // blink_lit selects the lit half of a blinking green; dir picks the
  // emergency green side (0 = X, 1 = Y). Red and green of one road are
  // never lit together, and the two greens are never lit together.
  function automatic lamps_t lamp_decode(phase_e ph, logic blink_lit, logic dir);
    lamps_t l;
    l = '0;
    case (ph)
      XG: begin
        l.gx  = 1'b1;
        l.ry  = 1'b1;
        l.seg = 1'b1;
      end
      XB: begin
        l.gx  = blink_lit;
        l.ry  = 1'b1;
        l.seg = 1'b1;
      end
      YG: begin
        l.gy = 1'b1;
        l.rx = 1'b1;
      end
      YB: begin
        l.gy = blink_lit;
        l.rx = 1'b1;
      end
      EMG: begin
        if (dir) begin
          l.gy = 1'b1;
          l.rx = 1'b1;
        end else begin
          l.gx = 1'b1;
          l.ry = 1'b1;
        end
      end
      default: begin
        l.rx = 1'b1;
        l.ry = 1'b1;
      end
    endcase
    return l;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Tick-gated down counter used as the per-state timer.
//   clk      : clock
//   rst_n    : synchronous reset, active HIGH (1 = reset)
//   tick_en  : timebase strobe; count/elapsed move only when high
//   load     : load load_val and clear elapsed (has priority over tick_en)
//   load_val : value loaded into the counter (duration - 1)
//   count    : ticks left in the current state
//   zero     : count == 0
//   elapsed  : ticks consumed since the last load
module phase_timer
  import traffic_pkg::*;
#(
  parameter int RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_en,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  output logic [TMR_W-1:0] count,
  output logic             zero,
  output logic [TMR_W-1:0] elapsed
);

  // NOTE: rst_n is active-high despite its name and is sampled on the clock
  // edge, so it lives inside the clocked branch rather than the sensitivity list.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      count   <= TMR_W'(RST_VAL);
      elapsed <= '0;
    end else if (load) begin
      count   <= load_val;
      elapsed <= '0;
    end else if (tick_en) begin
      // Both saturate: the emergency hold state parks at zero indefinitely.
      if (count != '0) count <= count - 1'b1;
      if (elapsed != '1) elapsed <= elapsed + 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/traffic_phase_sched.sv
// Two-road traffic phase scheduler with request truncation and emergency
// preemption.
//   clk        : clock
//   rst_n      : synchronous reset, active HIGH (1 = reset)
//   tick_en    : timebase strobe; all timers advance only on tick_en
//   req_x/y    : one-cycle demand pulses, latched as sticky pending flags
//   emg_req    : level emergency request; emg_dir picks the green side
//   Gx,Rx,Gy,Ry: registered lamp drives
//   seg_signal : X road owns the phase (XG, XB)
//   remain     : ticks left in the current timed state (0 in EMG)
//   phase      : current state encoding (traffic_pkg::phase_e)
module traffic_phase_sched
  import traffic_pkg::*;
#(
  parameter int GX_T       = GX_T_DEF,
  parameter int GY_T       = GY_T_DEF,
  parameter int BLINK_T    = BLINK_T_DEF,
  parameter int BLINK_HALF = BLINK_HALF_DEF,
  parameter int CLR_T      = CLR_T_DEF,
  parameter int MIN_G      = MIN_G_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_en,
  input  logic       req_x,
  input  logic       req_y,
  input  logic       emg_req,
  input  logic       emg_dir,
  output logic       Gx,
  output logic       Rx,
  output logic       Gy,
  output logic       Ry,
  output logic       seg_signal,
  output logic [9:0] remain,
  output logic [2:0] phase
);

  // Truncation fires on the tick that completes the MIN_G-th green tick,
  // i.e. when MIN_G-1 ticks have already been consumed.
  localparam logic [TMR_W-1:0] MIN_G_M1 = TMR_W'((MIN_G > 0) ? MIN_G - 1 : 0);
  localparam logic [TMR_W-1:0] HALF_M1  = TMR_W'(BLINK_HALF - 1);

  phase_e           state_q, state_n;
  logic             pend_x_q, pend_x_n;
  logic             pend_y_q, pend_y_n;
  logic             dir_q;
  logic [TMR_W-1:0] half_q, half_n;
  logic             lit_q, lit_n;
  lamps_t           lamps_n;

  logic             tmr_load;
  logic [TMR_W-1:0] tmr_load_val;
  logic [TMR_W-1:0] tmr_count;
  logic             tmr_zero;
  logic [TMR_W-1:0] tmr_elapsed;

  function automatic logic [TMR_W-1:0] dur_m1(phase_e ph);
    case (ph)
      XG:                     return TMR_W'(GX_T - 1);
      YG:                     return TMR_W'(GY_T - 1);
      XB, YB:                 return TMR_W'(BLINK_T - 1);
      CLR_XY, CLR_YX, EMG_CLR: return TMR_W'(CLR_T - 1);
      default:                return '0;
    endcase
  endfunction

  phase_timer #(
    .RST_VAL (CLR_T - 1)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick_en  (tick_en),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .count    (tmr_count),
    .zero     (tmr_zero),
    .elapsed  (tmr_elapsed)
  );

  // NOTE: every signal assigned here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_n = state_q;
    half_n  = half_q;
    lit_n   = lit_q;

    // Preemption is not tick-gated: it reacts on the very next clock.
    if (emg_req && state_q != EMG_CLR && state_q != EMG) begin
      state_n = EMG_CLR;
    end else begin
      case (state_q)
        XG:      if (tick_en && (tmr_zero || (pend_y_q && tmr_elapsed >= MIN_G_M1))) state_n = XB;
        XB:      if (tick_en && tmr_zero) state_n = CLR_XY;
        CLR_XY:  if (tick_en && tmr_zero) state_n = YG;
        YG:      if (tick_en && (tmr_zero || (pend_x_q && tmr_elapsed >= MIN_G_M1))) state_n = YB;
        YB:      if (tick_en && tmr_zero) state_n = CLR_YX;
        CLR_YX:  if (tick_en && tmr_zero) state_n = XG;
        EMG_CLR: if (tick_en && tmr_zero) state_n = emg_req ? EMG : CLR_YX;
        EMG:     if (!emg_req) state_n = dir_q ? CLR_YX : CLR_XY;
        default: state_n = CLR_YX;
      endcase
    end

    // No state ever transitions to itself, so a change of state is exactly
    // a state entry and the timer reloads with the new duration.
    tmr_load     = (state_n != state_q);
    tmr_load_val = dur_m1(state_n);

    // A request pulse coincident with the entry clear still wins.
    pend_x_n = req_x | (pend_x_q & ~(tmr_load && state_n == XG));
    pend_y_n = req_y | (pend_y_q & ~(tmr_load && state_n == YG));

    // Blink: first half-period dark, then alternate every BLINK_HALF ticks.
    if (tmr_load) begin
      half_n = '0;
      lit_n  = 1'b0;
    end else if (tick_en && (state_q == XB || state_q == YB)) begin
      if (half_q == HALF_M1) begin
        half_n = '0;
        lit_n  = ~lit_q;
      end else begin
        half_n = half_q + 1'b1;
      end
    end

    // Lamps are decoded from next-state values so the registered outputs
    // change on the same edge as the state; in EMG the live emg_dir is used
    // so a direction change shows up one clock later.
    lamps_n = lamp_decode(state_n, lit_n, emg_dir);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q    <= CLR_YX;
      pend_x_q   <= 1'b0;
      pend_y_q   <= 1'b0;
      dir_q      <= 1'b0;
      half_q     <= '0;
      lit_q      <= 1'b0;
      Gx         <= 1'b0;
      Rx         <= 1'b1;
      Gy         <= 1'b0;
      Ry         <= 1'b1;
      seg_signal <= 1'b0;
    end else begin
      state_q    <= state_n;
      pend_x_q   <= pend_x_n;
      pend_y_q   <= pend_y_n;
      if (emg_req) dir_q <= emg_dir;
      half_q     <= half_n;
      lit_q      <= lit_n;
      Gx         <= lamps_n.gx;
      Rx         <= lamps_n.rx;
      Gy         <= lamps_n.gy;
      Ry         <= lamps_n.ry;
      seg_signal <= lamps_n.seg;
    end
  end

  // Both are plain register outputs: the timer parks at zero in EMG.
  assign remain = tmr_count;
  assign phase  = state_q;

endmodule

// File: tb/tb_traffic_phase_sched.sv
// Scoreboard bench: each driven cycle runs a tick-counting reference model
// and queues the outputs expected after the next edge; a monitor pops and
// compares on every falling edge, plus a lamp-safety check.
module tb_traffic_phase_sched;
  import traffic_pkg::*;

  localparam int P_GX    = 300;
  localparam int P_GY    = 150;
  localparam int P_BLINK = 40;
  localparam int P_HALF  = 10;
  localparam int P_CLR   = 20;
  localparam int P_MING  = 100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       tick_en = 1'b0;
  logic       req_x = 1'b0;
  logic       req_y = 1'b0;
  logic       emg_req = 1'b0;
  logic       emg_dir = 1'b0;
  logic       Gx, Rx, Gy, Ry, seg_signal;
  logic [9:0] remain;
  logic [2:0] phase;

  traffic_phase_sched #(
    .GX_T(P_GX), .GY_T(P_GY), .BLINK_T(P_BLINK),
    .BLINK_HALF(P_HALF), .CLR_T(P_CLR), .MIN_G(P_MING)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick_en(tick_en),
    .req_x(req_x), .req_y(req_y), .emg_req(emg_req), .emg_dir(emg_dir),
    .Gx(Gx), .Rx(Rx), .Gy(Gy), .Ry(Ry), .seg_signal(seg_signal),
    .remain(remain), .phase(phase)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] ph;
    logic       gx, rx, gy, ry, seg;
    logic [9:0] rem;
  } exp_t;

  exp_t   sb_q[$];
  int     total = 0;
  int     bad = 0;
  int     cyc = 0;

  // Reference model: phase name, ticks already spent in it, request memory.
  phase_e m_ph = CLR_YX;
  int     m_done = 0;
  bit     m_px = 0, m_py = 0, m_dir = 0;

  function automatic int dur(phase_e p);
    case (p)
      XG:      return P_GX;
      YG:      return P_GY;
      XB, YB:  return P_BLINK;
      EMG:     return 1;
      default: return P_CLR;
    endcase
  endfunction

  function automatic phase_e after(phase_e p, bit er);
    case (p)
      XG:      return XB;
      XB:      return CLR_XY;
      CLR_XY:  return YG;
      YG:      return YB;
      YB:      return CLR_YX;
      CLR_YX:  return XG;
      EMG_CLR: return er ? EMG : CLR_YX;
      default: return CLR_YX;
    endcase
  endfunction

  task automatic model_step(input bit rs, tk, rx, ry, er, ed);
    phase_e nxt;
    exp_t   e;
    bit     lit;
    if (rs) begin
      m_ph = CLR_YX; m_done = 0; m_px = 0; m_py = 0; m_dir = 0;
    end else begin
      nxt = m_ph;
      if (er && m_ph != EMG_CLR && m_ph != EMG) nxt = EMG_CLR;
      else if (m_ph == EMG) begin
        if (!er) nxt = m_dir ? CLR_YX : CLR_XY;
      end else if (tk) begin
        if (m_done + 1 == dur(m_ph)) nxt = after(m_ph, er);
        else if (m_ph == XG && m_py && m_done + 1 >= P_MING) nxt = XB;
        else if (m_ph == YG && m_px && m_done + 1 >= P_MING) nxt = YB;
      end
      if (nxt != m_ph && nxt == XG) m_px = 0;
      if (nxt != m_ph && nxt == YG) m_py = 0;
      if (rx) m_px = 1;
      if (ry) m_py = 1;
      if (er) m_dir = ed;
      if (nxt != m_ph) m_done = 0;
      else if (tk) m_done++;
      m_ph = nxt;
    end
    e = '0;
    e.ph  = m_ph;
    e.rem = (m_ph == EMG) ? 10'd0 : 10'(dur(m_ph) - 1 - m_done);
    lit = ((m_done / P_HALF) % 2) == 1;
    case (m_ph)
      XG:  begin e.gx = 1; e.ry = 1; e.seg = 1; end
      XB:  begin e.gx = lit; e.ry = 1; e.seg = 1; end
      YG:  begin e.gy = 1; e.rx = 1; end
      YB:  begin e.gy = lit; e.rx = 1; end
      EMG: begin
        if (ed) begin e.gy = 1; e.rx = 1; end
        else begin e.gx = 1; e.ry = 1; end
      end
      default: begin e.rx = 1; e.ry = 1; end
    endcase
    sb_q.push_back(e);
  endtask

  // One clock of stimulus: drive, predict, advance past the edge.
  task automatic cycle(input bit rs, tk, rx, ry, er, ed);
    rst_n = rs; tick_en = tk; req_x = rx; req_y = ry; emg_req = er; emg_dir = ed;
    model_step(rs, tk, rx, ry, er, ed);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s @%0t: got %0h, required %0h", name, $time, got, req);
    end
  endtask

  // Idle cycles (no requests) until the model reaches phase p with d ticks done.
  task automatic wait_for(input phase_e p, input int d, input int mode, input int budget);
    int n = 0;
    while (!(m_ph == p && m_done == d) && n < budget) begin
      cycle(0, gen_tick(mode), 0, 0, 0, 0);
      n++;
    end
    if (n >= budget) check("wait_budget", 32'(n), 32'(budget - 1));
  endtask

  function automatic bit gen_tick(input int mode);
    case (mode)
      0:       return 1'b1;
      1:       return (cyc % 4) == 0;
      default: return $urandom_range(0, 3) != 0;
    endcase
  endfunction

  // Monitor: one scoreboard comparison and one safety check per cycle.
  initial begin
    exp_t e, got;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (sb_q.size() == 0) begin
        check("scoreboard_underrun", 32'd0, 32'd1);
      end else begin
        e   = sb_q.pop_front();
        got = {phase, Gx, Rx, Gy, Ry, seg_signal, remain};
        total++;
        if (got !== e) begin
          bad++;
          $display("FAIL outputs @%0t: got ph=%0d GxRxGyRy=%b%b%b%b seg=%b rem=%0d, required ph=%0d GxRxGyRy=%b%b%b%b seg=%b rem=%0d",
                   $time, got.ph, got.gx, got.rx, got.gy, got.ry, got.seg, got.rem,
                   e.ph, e.gx, e.rx, e.gy, e.ry, e.seg, e.rem);
        end
      end
      check("lamp_safety", 32'((Gx & Rx) | (Gy & Ry) | (Gx & Gy)), 32'd0);
    end
  end

  initial begin
    bit ed = 0;
    int emg_left = 0;
    bit er, rs, tk;

    // Reset, then free-running default cycle with every cycle a tick.
    repeat (3) cycle(1, 1, 0, 0, 0, 0);
    repeat (1200) cycle(0, 1, 0, 0, 0, 0);

    // Y request at XG tick 10: truncation after 100 green ticks.
    wait_for(XG, 10, 0, 2000);
    cycle(0, 1, 0, 1, 0, 0);
    repeat (400) cycle(0, 1, 0, 0, 0, 0);

    // Emergency toward Y raised during XG, held, then released.
    wait_for(XG, 5, 0, 2000);
    repeat (80) cycle(0, 1, 0, 0, 1, 1);
    repeat (700) cycle(0, 1, 0, 0, 0, 0);

    // Tick every 4th cycle, a truncating request and an emergency toward X.
    repeat (2500) cycle(0, gen_tick(1), 0, 0, 0, 0);
    wait_for(YG, 3, 1, 3000);
    cycle(0, gen_tick(1), 1, 0, 0, 0);
    repeat (600) cycle(0, gen_tick(1), 0, 0, 0, 0);
    cycle(0, gen_tick(1), 0, 0, 1, 0);
    repeat (150) cycle(0, gen_tick(1), 0, 0, 1, 0);
    repeat (40) cycle(0, gen_tick(1), 0, 0, 1, 1);
    repeat (400) cycle(0, gen_tick(1), 0, 0, 0, 0);

    // One-cycle reset in the middle of YB.
    wait_for(YB, 7, 0, 2000);
    cycle(1, 1, 0, 0, 1, 1);
    repeat (50) cycle(0, 1, 0, 0, 0, 0);

    // Randomized traffic: ticks, requests, emergency bursts, rare resets.
    repeat (14000) begin
      tk = gen_tick(2);
      if (emg_left > 0) begin
        emg_left--;
        if ($urandom_range(0, 39) == 0) ed = ~ed;
      end else if ($urandom_range(0, 1499) == 0) begin
        emg_left = $urandom_range(5, 120);
        ed = 1'($urandom);
      end
      er = (emg_left > 0);
      rs = ($urandom_range(0, 4999) == 0);
      cycle(rs, tk, $urandom_range(0, 59) == 0, $urandom_range(0, 59) == 0, er, ed);
    end

    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/traffic_phase_sched.md
TRAFFIC_PHASE_SCHED -- requirements
Module: traffic_phase_sched

Interface
REQ-001 SHALL have parameter GX_T, default 300, X-green duration in ticks (blink excluded).
REQ-002 SHALL have parameter GY_T, default 150, Y-green duration in ticks (blink excluded).
REQ-003 SHALL have parameter BLINK_T, default 40, blinking-green warning duration in ticks; even, 2..1023.
REQ-004 SHALL have parameter BLINK_HALF, default 10, ticks per blink half-period.
REQ-005 SHALL have parameter CLR_T, default 20, all-red clearance duration in ticks.
REQ-006 SHALL have parameter MIN_G, default 100, minimum green ticks served before a cross request may truncate green.
REQ-007 SHALL have port clk, input, 1, the single clock.
REQ-008 SHALL have port rst_n, input, 1; reset is synchronous and active-high (1 = reset, despite the name).
REQ-009 SHALL have port tick_en, input, 1, timebase strobe; timers advance only on cycles with tick_en=1.
REQ-010 SHALL have port req_x, input, 1, one-cycle pulse: X-side demand to get green.
REQ-011 SHALL have port req_y, input, 1, one-cycle pulse: Y-side demand to get green.
REQ-012 SHALL have port emg_req, input, 1, level emergency preemption request.
REQ-013 SHALL have port emg_dir, input, 1, preemption direction (0 = X, 1 = Y), sampled while emg_req=1.
REQ-014 SHALL have ports Gx, Rx, Gy, Ry, output, 1 each, lamp drives (1 = lit).
REQ-015 SHALL have port seg_signal, output, 1, high while the X road owns the phase (XG, XB).
REQ-016 SHALL have port remain, output, 10, ticks left in current timed state (0 in EMG).
REQ-017 SHALL have port phase, output, 3, current state encoding.

Function
REQ-018 SHALL implement states XG, XB, CLR_XY, YG, YB, CLR_YX, EMG_CLR, EMG.
REQ-019 SHALL load the timer with duration-1 on state entry and decrement on each tick_en; state exits on tick_en with timer=0, so a state lasts exactly its duration in ticks.
REQ-020 SHALL sequence XG(GX_T) -> XB(BLINK_T) -> CLR_XY(CLR_T) -> YG(GY_T) -> YB(BLINK_T) -> CLR_YX(CLR_T) -> XG.
REQ-021 SHALL set a sticky pending flag on req_y (req_x); in XG (YG) with pending req_y (req_x) and elapsed ticks >= MIN_G, the next tick SHALL enter XB (YB).
REQ-022 SHALL clear pending_x on entry to XG and pending_y on entry to YG; a set pulse coincident with the clear SHALL win.
REQ-023 SHALL, on emg_req=1 in any state except EMG_CLR/EMG, enter EMG_CLR on the next clock (not tick-gated), all-red for CLR_T ticks.
REQ-024 SHALL, from EMG_CLR, enter EMG if emg_req=1 else CLR_YX; EMG drives green only on emg_dir side, red on the other, and follows emg_dir changes within one clock.
REQ-025 SHALL, on emg_req=0 in EMG, enter CLR_XY if last emg_dir=0 else CLR_YX.
REQ-026 SHALL drive lamps: XG Gx=1,Ry=1; XB Ry=1, Gx=1 in odd blink halves (first half off); YG/YB symmetric; CLR_* and EMG_CLR Rx=Ry=1; Gx/Rx and Gy/Ry never both 1.
REQ-027 SHALL register all outputs, updated on the same edge as the state change.
REQ-028 SHALL ignore req_x/req_y for truncation in blink, clearance and emergency states but still latch them.

Reset
REQ-029 SHALL on rst_n=1 enter CLR_YX with timer CLR_T-1, clear pending flags, drive Rx=Ry=1, Gx=Gy=0, seg_signal=0, remain=CLR_T-1.
REQ-030 SHALL have reset override all inputs including emg_req, mid-phase included.

Structure
REQ-031 SHALL take the state encoding and default timing constants from shared package traffic_pkg.
REQ-032 SHALL instantiate one sub-module phase_timer (tick-gated 10-bit down counter with load, zero flag, elapsed count).

Verification
REQ-033 tick_en=1, no requests, defaults -> XG 300, XB 40, CLR 20, YG 150, YB 40, CLR 20 cycles, repeating.
REQ-034 req_y pulse at XG tick 10 -> XB entered after tick 100, pending_y cleared on YG entry.
REQ-035 emg_req=1, emg_dir=1 during XG -> EMG_CLR 20 ticks, then Gy=1, Rx=1 until emg_req=0, then CLR_YX, XG.
REQ-036 tick_en every 4th cycle -> all state durations scale x4; emg entry still one clock.
REQ-037 rst_n=1 for one cycle during YB -> next cycle Rx=Ry=1, phase=CLR_YX, remain=19.
REQ-038 Every cycle assert no Gx&Rx, no Gy&Ry, no Gx&Gy.
